// File: rtl/m2_block_scheduler.sv
// Milestone 2 block scheduler: sequences the FS/CT/CS/WS units over all
// 8x8 blocks of a frame in lead-in / common-case / lead-out order, and
// hands the single SRAM port to FS (reads) or WS (writes) by phase.
module m2_block_scheduler #(
    parameter int NUM_BLOCKS = 2400
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        M2_start,
    output logic        M2_done,
    output logic        FS_start,
    output logic        CT_start,
    output logic        CS_start,
    output logic        WS_start,
    input  logic        FS_done,
    input  logic        CT_done,
    input  logic        CS_done,
    input  logic        WS_done,
    input  logic [17:0] FS_SRAM_address,
    input  logic [17:0] WS_SRAM_address,
    input  logic [15:0] WS_SRAM_write_data,
    input  logic        WS_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [11:0] block_count
);

    localparam logic [11:0] NB = 12'(NUM_BLOCKS);

    // Unit bit positions inside every 4-bit unit vector: {WS, CS, CT, FS}
    localparam int U_FS = 0;
    localparam int U_CT = 1;
    localparam int U_CS = 2;
    localparam int U_WS = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LI_FS,
        S_LI_CT,
        S_CC_CSFS,
        S_CC_CTWS,
        S_LO_CS,
        S_LO_WS,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  w_done_in;
    logic [3:0]  r_done_q;
    logic [3:0]  w_evt;
    logic [3:0]  w_active;
    logic [3:0]  r_flag;
    logic [3:0]  w_flag_next;
    logic [3:0]  r_start;
    logic [3:0]  w_start_next;
    logic [11:0] r_k;
    logic [11:0] w_k_next;
    logic [11:0] r_w;
    logic [11:0] w_w_next;
    logic        w_all_done;

    // Which units a state is running; also the start set on entry to it.
    function automatic logic [3:0] active_mask(input state_t s);
        logic [3:0] m;
        m = 4'b0000;
        case (s)
            S_LI_FS:   m[U_FS] = 1'b1;
            S_LI_CT:   m[U_CT] = 1'b1;
            S_CC_CSFS: begin m[U_CS] = 1'b1; m[U_FS] = 1'b1; end
            S_CC_CTWS: begin m[U_CT] = 1'b1; m[U_WS] = 1'b1; end
            S_LO_CS:   m[U_CS] = 1'b1;
            S_LO_WS:   m[U_WS] = 1'b1;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    assign w_done_in = {WS_done, CS_done, CT_done, FS_done};
    assign w_active  = active_mask(r_state);

    // Rising-edge events, kept only for units the current state is waiting on
    for (genvar gi = 0; gi < 4; gi++) begin : g_evt
        assign w_evt[gi] = w_done_in[gi] & ~r_done_q[gi] & w_active[gi];
    end

    // Exit as soon as the last outstanding unit's edge is seen
    assign w_all_done = (w_active != 4'b0000) &&
                        (((r_flag | w_evt) & w_active) == w_active);

    // Next-state, fetch index and written-block count
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_w_next     = r_w;
        case (r_state)
            S_IDLE: begin
                if (M2_start) begin
                    w_state_next = S_LI_FS;
                    w_k_next     = 12'd0;
                    w_w_next     = 12'd0;
                end
            end
            S_LI_FS: begin
                if (w_all_done) begin
                    w_state_next = S_LI_CT;
                    w_k_next     = 12'd1;
                end
            end
            S_LI_CT: begin
                if (w_all_done)
                    w_state_next = (r_k < NB) ? S_CC_CSFS : S_LO_CS;
            end
            S_CC_CSFS: begin
                if (w_all_done) begin
                    w_state_next = S_CC_CTWS;
                    w_k_next     = r_k + 12'd1;
                end
            end
            S_CC_CTWS: begin
                if (w_all_done) begin
                    w_w_next     = r_w + 12'd1;
                    w_state_next = (r_k < NB) ? S_CC_CSFS : S_LO_CS;
                end
            end
            S_LO_CS: begin
                if (w_all_done)
                    w_state_next = S_LO_WS;
            end
            S_LO_WS: begin
                if (w_all_done) begin
                    w_w_next     = r_w + 12'd1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Flags accumulate within a state and clear on any state change;
    // starts fire only on entry, so they last exactly one cycle.
    assign w_flag_next  = (w_state_next != r_state) ? 4'b0000 : (r_flag | w_evt);
    assign w_start_next = (w_state_next != r_state) ? active_mask(w_state_next) : 4'b0000;

    // State register
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Edge latches, completion flags, start pulses and counters
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_done_q <= 4'b0000;
            r_flag   <= 4'b0000;
            r_start  <= 4'b0000;
            r_k      <= 12'd0;
            r_w      <= 12'd0;
        end else begin
            r_done_q <= w_done_in;
            r_flag   <= w_flag_next;
            r_start  <= w_start_next;
            r_k      <= w_k_next;
            r_w      <= w_w_next;
        end
    end

    assign FS_start    = r_start[U_FS];
    assign CT_start    = r_start[U_CT];
    assign CS_start    = r_start[U_CS];
    assign WS_start    = r_start[U_WS];
    assign M2_done     = (r_state == S_DONE);
    assign block_count = r_w;

    // SRAM port ownership by phase; FS is read-only so its we_n stays high
    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        case (r_state)
            S_LI_FS, S_CC_CSFS: begin
                SRAM_address = FS_SRAM_address;
            end
            S_CC_CTWS, S_LO_WS: begin
                SRAM_address    = WS_SRAM_address;
                SRAM_write_data = WS_SRAM_write_data;
                SRAM_we_n       = WS_SRAM_we_n;
            end
            default: begin
                SRAM_address    = 18'd0;
                SRAM_write_data = 16'd0;
                SRAM_we_n       = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: a 3-block instance (random-latency unit
// models plus hand-driven done levels) and a 1-block instance.
module tb_m2_block_scheduler;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    // ---------------- instance A: NUM_BLOCKS = 3 ----------------
    logic        a_m2_start, a_m2done;
    logic        a_fs_start, a_ct_start, a_cs_start, a_ws_start;
    logic [3:0]  a_start, a_done, a_man_done;
    logic [3:0]  m_done = 4'b0000;
    logic        a_auto;
    logic [17:0] a_fs_addr, a_ws_addr, a_sram_addr;
    logic [15:0] a_ws_data, a_sram_data;
    logic        a_ws_we_n, a_sram_we_n;
    logic [11:0] a_bcnt;

    assign a_start = {a_ws_start, a_cs_start, a_ct_start, a_fs_start};
    assign a_done  = a_auto ? m_done : a_man_done;

    m2_block_scheduler #(.NUM_BLOCKS(3)) u_dut_a (
        .CLOCK_50_I(clk), .Resetn(rstn), .M2_start(a_m2_start), .M2_done(a_m2done),
        .FS_start(a_fs_start), .CT_start(a_ct_start), .CS_start(a_cs_start), .WS_start(a_ws_start),
        .FS_done(a_done[0]), .CT_done(a_done[1]), .CS_done(a_done[2]), .WS_done(a_done[3]),
        .FS_SRAM_address(a_fs_addr), .WS_SRAM_address(a_ws_addr),
        .WS_SRAM_write_data(a_ws_data), .WS_SRAM_we_n(a_ws_we_n),
        .SRAM_address(a_sram_addr), .SRAM_write_data(a_sram_data), .SRAM_we_n(a_sram_we_n),
        .block_count(a_bcnt)
    );

    // ---------------- instance B: NUM_BLOCKS = 1 ----------------
    logic        b_m2_start, b_m2done;
    logic        b_fs_start, b_ct_start, b_cs_start, b_ws_start;
    logic [3:0]  b_start, b_man_done;
    logic [17:0] b_fs_addr, b_ws_addr, b_sram_addr;
    logic [15:0] b_ws_data, b_sram_data;
    logic        b_ws_we_n, b_sram_we_n;
    logic [11:0] b_bcnt;

    assign b_start = {b_ws_start, b_cs_start, b_ct_start, b_fs_start};

    m2_block_scheduler #(.NUM_BLOCKS(1)) u_dut_b (
        .CLOCK_50_I(clk), .Resetn(rstn), .M2_start(b_m2_start), .M2_done(b_m2done),
        .FS_start(b_fs_start), .CT_start(b_ct_start), .CS_start(b_cs_start), .WS_start(b_ws_start),
        .FS_done(b_man_done[0]), .CT_done(b_man_done[1]), .CS_done(b_man_done[2]), .WS_done(b_man_done[3]),
        .FS_SRAM_address(b_fs_addr), .WS_SRAM_address(b_ws_addr),
        .WS_SRAM_write_data(b_ws_data), .WS_SRAM_we_n(b_ws_we_n),
        .SRAM_address(b_sram_addr), .SRAM_write_data(b_sram_data), .SRAM_we_n(b_sram_we_n),
        .block_count(b_bcnt)
    );

    // Unit models for A: on start drop done, raise it 5..20 cycles later and hold
    int m_cnt [4];
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (!rstn) begin
                m_cnt[u] = 0;
            end else if (a_start[u]) begin
                m_done[u] = 1'b0;
                m_cnt[u]  = $urandom_range(5, 20);
            end else if (m_cnt[u] > 0) begin
                m_cnt[u] = m_cnt[u] - 1;
                if (m_cnt[u] == 0) m_done[u] = 1'b1;
            end
        end
    end

    // Monitor for A: log every non-empty start set and count M2_done pulses
    logic [3:0] a_seq [$];
    int         a_done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (a_start != 4'b0000) a_seq.push_back(a_start);
        if (a_m2done) a_done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a_start();
        a_m2_start = 1'b1;
        tick();
        a_m2_start = 1'b0;
    endtask

    task automatic wait_a_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (a_m2done) seen = 1'b1;
        end
        check_val(tag, {31'd0, seen}, 32'd1);
    endtask

    // Expected start order for 3 blocks, bits {WS,CS,CT,FS}
    task automatic check_seq3(input string p, input int base);
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};
        check_val({p, "_seq_len"}, a_seq.size() - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < a_seq.size())
                check_val($sformatf("%s_seq%0d", p, i), {28'd0, a_seq[base + i]}, {28'd0, exp_seq[i]});
        end
    endtask

    // Hand-driven edge on the given A units: drop, then raise one cycle later
    task automatic edge_a(input logic [3:0] m);
        a_man_done = a_man_done & ~m;
        tick();
        a_man_done = a_man_done | m;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int         base;
        int         dcnt;
        logic [3:0] any_start;

        rstn = 1'b0;
        a_m2_start = 1'b0; b_m2_start = 1'b0;
        a_auto = 1'b1; a_man_done = 4'b0000; b_man_done = 4'b0000;
        a_fs_addr = 18'd0; a_ws_addr = 18'd0; a_ws_data = 16'd0; a_ws_we_n = 1'b1;
        b_fs_addr = 18'h00777; b_ws_addr = 18'h00555; b_ws_data = 16'h1234; b_ws_we_n = 1'b0;
        repeat (2) tick();

        // Reset values
        check_val("rst_a_starts", {28'd0, a_start}, 32'd0);
        check_val("rst_a_m2done", {31'd0, a_m2done}, 32'd0);
        check_val("rst_a_bcnt", {20'd0, a_bcnt}, 32'd0);
        check_val("rst_a_we_n", {31'd0, a_sram_we_n}, 32'd1);
        check_val("rst_a_addr", {14'd0, a_sram_addr}, 32'd0);
        check_val("rst_b_starts", {28'd0, b_start}, 32'd0);
        rstn = 1'b1;
        tick();

        // Single-block frame on B: FS, CT, CS, WS, then M2_done one cycle after the WS edge
        b_m2_start = 1'b1; tick(); b_m2_start = 1'b0;
        check_val("b_fs_start", {28'd0, b_start}, 32'b0001);
        check_val("b_fs_addr", {14'd0, b_sram_addr}, 32'h00777);
        check_val("b_fs_we_n", {31'd0, b_sram_we_n}, 32'd1);
        b_man_done[0] = 1'b1; tick();
        check_val("b_ct_start", {28'd0, b_start}, 32'b0010);
        b_man_done[1] = 1'b1; tick();
        check_val("b_cs_start", {28'd0, b_start}, 32'b0100);
        b_man_done[2] = 1'b1; tick();
        check_val("b_ws_start", {28'd0, b_start}, 32'b1000);
        check_val("b_ws_addr", {14'd0, b_sram_addr}, 32'h00555);
        b_man_done[3] = 1'b1; tick();
        check_val("b_m2done", {31'd0, b_m2done}, 32'd1);
        check_val("b_bcnt", {20'd0, b_bcnt}, 32'd1);
        tick();
        check_val("b_m2done_off", {31'd0, b_m2done}, 32'd0);

        // Three-block frame on A with random unit latencies and a stray M2_start mid-frame
        base = a_seq.size();
        dcnt = a_done_cnt;
        pulse_a_start();
        repeat (30) tick();
        pulse_a_start();
        wait_a_done("auto_frame_done", 1000);
        repeat (3) tick();
        check_seq3("auto", base);
        check_val("auto_done_cnt", a_done_cnt - dcnt, 32'd1);
        check_val("auto_bcnt", {20'd0, a_bcnt}, 32'd3);

        // Hand-driven frame on A; every done level is still high from the last frame
        a_man_done = 4'b1111;
        a_auto = 1'b0;
        a_fs_addr = 18'h12345;
        pulse_a_start();
        check_val("man_fs_start", {28'd0, a_start}, 32'b0001);
        check_val("man_lifs_addr", {14'd0, a_sram_addr}, 32'h12345);
        any_start = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_start = any_start | a_start;
        end
        check_val("held_fs_no_start", {28'd0, any_start}, 32'd0);
        check_val("held_fs_still_fs", {14'd0, a_sram_addr}, 32'h12345);
        edge_a(4'b0001);
        check_val("man_ct_start", {28'd0, a_start}, 32'b0010);
        check_val("man_lict_addr", {14'd0, a_sram_addr}, 32'd0);

        a_ws_addr = 18'h2A000; a_ws_we_n = 1'b0; a_ws_data = 16'hBEEF;
        edge_a(4'b0010);
        check_val("man_csfs_start", {28'd0, a_start}, 32'b0101);
        check_val("csfs_we_n_forced", {31'd0, a_sram_we_n}, 32'd1);
        check_val("csfs_addr_fs", {14'd0, a_sram_addr}, 32'h12345);

        // CS and FS finish in the same cycle
        edge_a(4'b0101);
        check_val("same_cycle_start", {28'd0, a_start}, 32'b1010);
        check_val("ctws_addr", {14'd0, a_sram_addr}, 32'h2A000);
        check_val("ctws_data", {16'd0, a_sram_data}, 32'hBEEF);
        check_val("ctws_we_n", {31'd0, a_sram_we_n}, 32'd0);

        edge_a(4'b1010);
        check_val("ctws1_start", {28'd0, a_start}, 32'b0101);
        check_val("ctws1_bcnt", {20'd0, a_bcnt}, 32'd1);

        // CS finishes, FS finishes 10 cycles later
        a_man_done = a_man_done & ~4'b0101;
        tick();
        a_man_done[2] = 1'b1;
        any_start = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_start = any_start | a_start;
        end
        check_val("gap_no_start", {28'd0, any_start}, 32'd0);
        a_man_done[0] = 1'b1;
        tick();
        check_val("gap_start", {28'd0, a_start}, 32'b1010);

        edge_a(4'b1010);
        check_val("lo_cs_start", {28'd0, a_start}, 32'b0100);
        check_val("lo_cs_bcnt", {20'd0, a_bcnt}, 32'd2);
        check_val("lo_cs_addr", {14'd0, a_sram_addr}, 32'd0);
        check_val("lo_cs_we_n", {31'd0, a_sram_we_n}, 32'd1);

        edge_a(4'b0100);
        check_val("lo_ws_start", {28'd0, a_start}, 32'b1000);
        check_val("lo_ws_we_n", {31'd0, a_sram_we_n}, 32'd0);

        edge_a(4'b1000);
        check_val("man_m2done", {31'd0, a_m2done}, 32'd1);
        check_val("man_bcnt", {20'd0, a_bcnt}, 32'd3);
        tick();
        check_val("man_m2done_off", {31'd0, a_m2done}, 32'd0);
        check_val("man_idle_we_n", {31'd0, a_sram_we_n}, 32'd1);

        // Reset asserted while block 2 of 3 is in flight, then a fresh full frame
        a_auto = 1'b1;
        repeat (25) tick();
        pulse_a_start();
        begin
            logic reached;
            reached = 1'b0;
            for (int i = 0; i < 500 && !reached; i++) begin
                tick();
                if (a_bcnt == 12'd1) reached = 1'b1;
            end
            check_val("reach_block2", {31'd0, reached}, 32'd1);
        end
        repeat (3) tick();
        rstn = 1'b0;
        #2;
        check_val("abort_starts", {28'd0, a_start}, 32'd0);
        check_val("abort_bcnt", {20'd0, a_bcnt}, 32'd0);
        check_val("abort_m2done", {31'd0, a_m2done}, 32'd0);
        check_val("abort_we_n", {31'd0, a_sram_we_n}, 32'd1);
        check_val("abort_addr", {14'd0, a_sram_addr}, 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        base = a_seq.size();
        dcnt = a_done_cnt;
        pulse_a_start();
        wait_a_done("rerun_frame_done", 1000);
        repeat (3) tick();
        check_seq3("rerun", base);
        check_val("rerun_done_cnt", a_done_cnt - dcnt, 32'd1);
        check_val("rerun_bcnt", {20'd0, a_bcnt}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
